seq_det_scheduler: RTL and testbench
====================================

# seq_det_scheduler

Round-robin scheduler that shares one serial `seq_101010_detector` (overlapping Mealy, ports `x`, `clk`, `reset`, `z`) among `N_REQ` bit-stream requesters. It grants one requester at a time and clears the detector before each frame. It then streams exactly `FRAME_LEN` bits from the granted requester into the detector, counts `z` pulses, and reports a per-frame match count tagged with the requester id. It sits between the serial input channels and the detector instance, which is external to this block.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2).
- `FRAME_LEN`, 16, bits per frame (≥1).
- `ID_W`, `$clog2(N_REQ)`, width of requester id.
- `CNT_W`, `$clog2(FRAME_LEN+1)`, width of match count.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in N_REQ: requester i has a frame pending (level).
- `bit_in` in N_REQ: serial data bit per requester.
- `bit_valid` in N_REQ: `bit_in[i]` valid this cycle.
- `bit_ready` out N_REQ: one-hot or zero; scheduler consumes `bit_in[i]` this cycle.
- `det_x` out 1: drives detector `x`.
- `det_rst` out 1: drives detector `reset`.
- `det_z` in 1: detector `z` (combinational from `det_x` and state).
- `busy` out 1: a frame is granted (states CLR, STREAM, DONE).
- `done` out 1: one-cycle pulse, frame finished.
- `done_id` out ID_W: requester id of finished frame.
- `match_cnt` out CNT_W: `z` pulses counted in that frame.
- `err` out 1: with `done`, frame aborted.

## Operation
- FSM states: IDLE, CLR, STREAM, DONE.
- IDLE
  - If any `req` is high, the round-robin arbiter picks the first requester at or after `rr_ptr` (searching upward, wrapping).
  - Latch the pick as `gnt_id`, then go to CLR.
- CLR
  - `det_rst`=1 for exactly one cycle.
  - Clear `bit_cnt` and `cnt`, then go to STREAM.
- STREAM
  - `bit_ready[gnt_id]`=1; all other `bit_ready` bits are 0.
  - `det_x = bit_valid[gnt_id] ? bit_in[gnt_id] : 0`, combinational.
  - On a handshake, `cnt += det_z` (same-cycle pairing) and `bit_cnt += 1`.
  - On the handshake with `bit_cnt == FRAME_LEN-1`, go to DONE with `err`=0.
- Abort in STREAM
  - The detector has no enable, so a granted requester must hold `bit_valid` high every STREAM cycle.
  - Any STREAM cycle with `bit_valid[gnt_id]`=0 sets `err`=1 and goes to DONE. That cycle is not counted.
- DONE
  - `done`=1, `done_id`=`gnt_id`, `match_cnt`=`cnt`.
  - `rr_ptr` ← `(gnt_id+1) mod N_REQ`, then go to IDLE.
- Outside STREAM: `det_x`=0 and `bit_ready`=0.
- `det_rst` = `reset` OR (state==CLR).
- `req` is sampled only in IDLE. A `req` drop during STREAM is ignored; only `bit_valid` matters.
- `cnt` cannot exceed `FRAME_LEN`, so no saturation logic is needed.

## Timing
- Reset: state=IDLE, `rr_ptr`=0, and all outputs 0 except `det_rst`=1.
- `reset` mid-frame discards the frame with no `done`. The detector is cleared through `det_rst`.
- `req` seen in IDLE at cycle t:
  - CLR at t+1.
  - First bit at t+2.
  - Last bit at t+FRAME_LEN+1.
  - DONE (`done`=1) at t+FRAME_LEN+2.
  - IDLE at t+FRAME_LEN+3.
- Back-to-back frames: 3 overhead cycles (IDLE, CLR, DONE) per frame.
- Outputs are registered except `det_x`, `det_rst` and `bit_ready`, which decode from state and inputs. `done`, `done_id`, `match_cnt` and `err` are valid only while `done`=1.
- Simultaneous requests: strict round-robin from `rr_ptr`. A requester that just finished has lowest priority next.

## Structure
- Shared package `seq_det_pkg`: state enum (IDLE, CLR, STREAM, DONE) and default `FRAME_LEN`.
- One sub-module: `rr_arbiter` (N_REQ requests, pointer in, one-hot grant and id out), purely combinational.
- The detector is instantiated by the parent, not inside this block.

## Test plan
- Basic frame: reset, `req[0]`=1, stream 1010101010100000 with `bit_valid` held high.
  - `done` at t+18, `done_id`=0, `match_cnt`=4, `err`=0.
  - `det_rst` high for one cycle at t+1.
- Arbitration: `req`=4'b1111 held high, each frame all zeros.
  - Grants in order 0,1,2,3,0.
  - Each `match_cnt`=0, with 3 idle/overhead cycles between data phases.
- Fairness: `req[2]` and `req[3]` high with `rr_ptr`=3 after a frame from requester 2.
  - Next grant goes to 3, then 2.
- State isolation: requester 1 ends its frame with 10101 (detector mid-match); requester 2 starts with 0.
  - Requester 2's `match_cnt` counts only its own matches (verify with frame 0101010…).
- Abort: drop `bit_valid[gnt]` at bit 5.
  - `done`=1 with `err`=1, `match_cnt` = matches counted before the drop.
  - Next frame proceeds normally.
- Reset mid-STREAM at bit 8.
  - No `done`, all outputs return to reset values.
  - Next grant starts from requester 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM state type and default frame length for the detector scheduler
package seq_det_pkg;
  typedef enum logic [1:0] {IDLE, CLR, STREAM, DONE} state_t;
  localparam int FRAME_LEN_DEF = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the pointer
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_gnt_id
);
  logic [ID_W:0] w_idx;
  logic w_found;
  always_comb begin
    o_gnt = '0;
    o_gnt_id = '0;
    w_found = 1'b0;
    w_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, i_ptr} + (ID_W+1)'(k);
      w_idx = (w_idx >= (ID_W+1)'(N_REQ)) ? w_idx - (ID_W+1)'(N_REQ) : w_idx;
      if (!w_found && i_req[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        o_gnt_id = w_idx[ID_W-1:0];
        o_gnt[w_idx[ID_W-1:0]] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: round-robin sharing of one external 101010 detector across serial requesters
module seq_det_scheduler import seq_det_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ID_W = $clog2(N_REQ),
  parameter int CNT_W = $clog2(FRAME_LEN+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] bit_in,
  input  logic [N_REQ-1:0] bit_valid,
  output logic [N_REQ-1:0] bit_ready,
  output logic             det_x,
  output logic             det_rst,
  input  logic             det_z,
  output logic             busy,
  output logic             done,
  output logic [ID_W-1:0]  done_id,
  output logic [CNT_W-1:0] match_cnt,
  output logic             err
);
  state_t r_state, w_next;
  logic [N_REQ-1:0] r_gnt_oh, w_arb_oh;
  logic [ID_W-1:0] r_gnt_id, r_rr_ptr, w_arb_id;
  logic [CNT_W-1:0] r_bit_cnt, r_cnt;
  logic r_busy, r_done, r_err;
  logic w_stream, w_valid, w_last;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .i_req(req), .i_ptr(r_rr_ptr), .o_gnt(w_arb_oh), .o_gnt_id(w_arb_id)
  );

  assign w_stream = r_state == STREAM;
  assign w_valid = bit_valid[r_gnt_id];
  assign w_last = r_bit_cnt == CNT_W'(FRAME_LEN-1);

  // a missing valid bit aborts the frame: the detector cannot be stalled
  always_comb begin
    w_next = (r_state == IDLE)   ? (|req ? CLR : IDLE) :
             (r_state == CLR)    ? STREAM :
             (r_state == STREAM) ? ((!w_valid || w_last) ? DONE : STREAM) : IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt_oh <= '0;
      r_gnt_id <= '0;
      r_rr_ptr <= '0;
      r_bit_cnt <= '0;
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy <= w_next != IDLE;
      r_done <= w_next == DONE;
      if (r_state == IDLE && |req) begin
        r_gnt_oh <= w_arb_oh;
        r_gnt_id <= w_arb_id;
      end
      if (r_state == CLR) begin
        r_bit_cnt <= '0;
        r_cnt <= '0;
        r_err <= 1'b0;
      end
      if (w_stream && w_valid) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_cnt <= r_cnt + CNT_W'(det_z);
      end
      if (w_stream && !w_valid) r_err <= 1'b1;
      if (r_state == DONE) r_rr_ptr <= (r_gnt_id == ID_W'(N_REQ-1)) ? '0 : r_gnt_id + 1'b1;
    end
  end

  assign bit_ready = w_stream ? r_gnt_oh : '0;
  assign det_x = w_stream & w_valid & bit_in[r_gnt_id];
  assign det_rst = reset | (r_state == CLR);
  assign busy = r_busy;
  assign done = r_done;
  assign done_id = r_gnt_id;
  assign match_cnt = r_cnt;
  assign err = r_err;
endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb_seq_det_scheduler: table-driven and randomized checks of the scheduler with a behavioural detector
module tb_seq_det_scheduler;
  localparam int N = 4;
  localparam int F = 16;
  localparam int IW = 2;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0, bit_in = '0, bit_valid = '0, bit_ready;
  logic det_x, det_rst, det_z, busy, done, err;
  logic [IW-1:0] done_id;
  logic [CW-1:0] match_cnt;
  logic [4:0] hist;

  always #5 clk = ~clk;

  seq_det_scheduler #(.N_REQ(N), .FRAME_LEN(F), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .det_x(det_x), .det_rst(det_rst), .det_z(det_z),
    .busy(busy), .done(done), .done_id(done_id), .match_cnt(match_cnt), .err(err)
  );

  // overlapping Mealy 101010 detector: last five bits 10101 and current bit 0
  always_ff @(posedge clk) hist <= det_rst ? 5'd0 : {hist[3:0], det_x};
  assign det_z = (hist == 5'b10101) && !det_x;

  logic [F-1:0] fr [N];
  int ab [N];
  int pos [N];
  int checks = 0, errors = 0;
  logic s_done, s_err, s_busy, s_rst, s_x;
  logic [IW-1:0] s_id;
  logic [CW-1:0] s_cnt;
  logic [N-1:0] s_rdy;

  typedef struct {
    bit rst;
    logic [N-1:0] req;
    logic [F-1:0] bits;
    int ab;
    int id;
    int cnt;
    int err;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      bit_valid[i] = (pos[i] < F) && (pos[i] != ab[i]);
      bit_in[i] = bit_valid[i] ? fr[i][F-1-pos[i]] : 1'b0;
    end
    #1;
    s_done = done; s_err = err; s_busy = busy; s_rst = det_rst; s_x = det_x;
    s_id = done_id; s_cnt = match_cnt; s_rdy = bit_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (s_rdy[i] && bit_valid[i]) pos[i]++;
  endtask

  function automatic int count_m(logic [F-1:0] b, int n);
    int c = 0;
    logic [5:0] w;
    for (int i = 5; i < n; i++) begin
      for (int k = 0; k < 6; k++) w[5-k] = b[F-1-(i-5+k)];
      if (w == 6'b101010) c++;
    end
    return c;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    tick();
    tick();
    chk("rst_det_rst", s_rst, 1);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_err", s_err, 0);
    chk("rst_ready", s_rdy, 0);
    chk("rst_det_x", s_x, 0);
    chk("rst_cnt", s_cnt, 0);
    reset = 1'b0;
  endtask

  task automatic run_frame(string nm, logic [N-1:0] mask, logic [F-1:0] bits, int a,
                           int eid, int ecnt, int eerr);
    int lat = 0, nrst = 0, roff = 0;
    logic got = 1'b0;
    req = mask;
    fr[eid] = bits;
    ab[eid] = a;
    pos[eid] = 0;
    while (!got && lat < F + 8) begin
      tick();
      lat++;
      if (s_rst) begin
        nrst++;
        roff = lat;
      end
      got = s_done;
    end
    chk({nm, "_done_seen"}, int'(got), 1);
    if (got) begin
      chk({nm, "_latency"}, lat, a < 0 ? F + 3 : a + 4);
      chk({nm, "_id"}, int'(s_id), eid);
      chk({nm, "_cnt"}, int'(s_cnt), ecnt);
      chk({nm, "_err"}, int'(s_err), eerr);
      chk({nm, "_busy"}, int'(s_busy), 1);
    end
    chk({nm, "_clr_pulses"}, nrst, 1);
    chk({nm, "_clr_cycle"}, roff, 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, ptr, id, a;
    logic [N-1:0] mask;
    logic [F-1:0] bits;
    logic saw;
    for (int i = 0; i < N; i++) begin
      fr[i] = '0;
      ab[i] = -1;
      pos[i] = F;
    end
    tbl[0]  = '{1, 4'b0001, 16'b1010101010100000, -1, 0, 4, 0};
    tbl[1]  = '{1, 4'b1111, 16'b0000000000000000, -1, 0, 0, 0};
    tbl[2]  = '{0, 4'b1111, 16'b0000000000000000, -1, 1, 0, 0};
    tbl[3]  = '{0, 4'b1111, 16'b0000000000000000, -1, 2, 0, 0};
    tbl[4]  = '{0, 4'b1111, 16'b0000000000000000, -1, 3, 0, 0};
    tbl[5]  = '{0, 4'b1111, 16'b0000000000000000, -1, 0, 0, 0};
    tbl[6]  = '{1, 4'b0100, 16'b1010100000000000, -1, 2, 1, 0};
    tbl[7]  = '{0, 4'b1100, 16'b0000000000000000, -1, 3, 0, 0};
    tbl[8]  = '{0, 4'b1100, 16'b0000000000000000, -1, 2, 0, 0};
    tbl[9]  = '{0, 4'b0010, 16'b0000000000010101, -1, 1, 0, 0};
    tbl[10] = '{0, 4'b0100, 16'b0101010000000000, -1, 2, 1, 0};
    tbl[11] = '{0, 4'b0001, 16'b1010101010100000,  5, 0, 0, 1};
    tbl[12] = '{0, 4'b0010, 16'b1010101010100000, -1, 1, 4, 0};
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rst) do_reset();
      run_frame($sformatf("v%0d", i), tbl[i].req, tbl[i].bits, tbl[i].ab,
                tbl[i].id, tbl[i].cnt, tbl[i].err);
    end

    do_reset();
    req = 4'b0100;
    fr[2] = 16'b1010101010101010;
    ab[2] = -1;
    pos[2] = 0;
    n = 0;
    saw = 1'b0;
    while (pos[2] < 8 && n < 20) begin
      tick();
      n++;
      saw |= s_done;
    end
    chk("mid_reach_bit8", pos[2], 8);
    reset = 1'b1;
    req = '0;
    tick();
    saw |= s_done;
    chk("mid_det_rst", s_rst, 1);
    tick();
    saw |= s_done;
    chk("mid_busy", s_busy, 0);
    chk("mid_ready", s_rdy, 0);
    chk("mid_det_x", s_x, 0);
    chk("mid_cnt", s_cnt, 0);
    chk("mid_err", s_err, 0);
    reset = 1'b0;
    tick();
    saw |= s_done;
    chk("mid_no_done", saw, 0);
    chk("mid_det_rst_low", s_rst, 0);
    run_frame("post_rst", 4'b1111, 16'b1010101010100000, -1, 0, 4, 0);

    do_reset();
    ptr = 0;
    for (int r = 0; r < 6; r++) begin
      mask = N'($urandom_range(1, 15));
      for (int j = 0; j < 6; j++) begin
        id = 0;
        for (int k = 0; k < N; k++) if (mask[(ptr + k) % N]) begin
          id = (ptr + k) % N;
          break;
        end
        bits = F'($urandom);
        a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, F - 1)) : -1;
        run_frame($sformatf("r%0d_%0d", r, j), mask, bits, a, id,
                  count_m(bits, a < 0 ? F : a), a >= 0 ? 1 : 0);
        ptr = (id + 1) % N;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
